// File: rtl/ps2_receptor_teclado_if.sv
// ps2_receptor_teclado_if: PS/2 lines in, decoded key code and strobes out
interface ps2_receptor_teclado_if;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] Cambio;
  logic       got_data;
  logic       extendido;
  logic       frame_err;
  modport master (output ps2c, ps2d, input Cambio, got_data, extendido, frame_err);
  modport slave  (input ps2c, ps2d, output Cambio, got_data, extendido, frame_err);
endinterface

// File: rtl/ps2_receptor_teclado.sv
// ps2_receptor_teclado: PS/2 frame receiver that strips E0/F0 prefixes and strobes make codes
module ps2_receptor_teclado #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input logic clk,
  input logic rst,
  ps2_receptor_teclado_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0]            c_sync, d_sync;
  logic [FILTER_LEN-1:0] filt;
  logic                  fclk, fclk_q, fall, din, valid;
  state_t                state;
  logic [2:0]            cnt;
  logic [7:0]            sh, cambio;
  logic                  par, brk, ext, got, extd, err;
  logic [TW-1:0]         tmo;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      filt   <= '1;
      fclk   <= 1'b1;
      fclk_q <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], bus.ps2c};
      d_sync <= {d_sync[0], bus.ps2d};
      filt   <= {filt[FILTER_LEN-2:0], c_sync[1]};
      fclk   <= &filt ? 1'b1 : ~|filt ? 1'b0 : fclk;
      fclk_q <= fclk;
    end
  end
  assign fall  = fclk_q & ~fclk;
  assign din   = d_sync[1];
  assign valid = din & (^{sh, par});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      tmo    <= '0;
      brk    <= 1'b0;
      ext    <= 1'b0;
      cambio <= '0;
      extd   <= 1'b0;
      got    <= 1'b0;
      err    <= 1'b0;
    end else begin
      got <= 1'b0;
      err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        case (state)
          IDLE: if (!din) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: begin
            sh  <= {din, sh[7:1]};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!valid) begin
              err <= 1'b1;
              brk <= 1'b0;
              ext <= 1'b0;
            end else if (sh == 8'hF0) brk <= 1'b1;
            else if (sh == 8'hE0) ext <= 1'b1;
            else if (brk) begin
              brk <= 1'b0;
              ext <= 1'b0;
            end else begin
              cambio <= sh;
              extd   <= ext;
              got    <= 1'b1;
              ext    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // a stalled keyboard abandons the partial frame and any pending prefix
        if (tmo == TW'(TIMEOUT - 1)) begin
          state <= IDLE;
          tmo   <= '0;
          err   <= 1'b1;
          brk   <= 1'b0;
          ext   <= 1'b0;
        end else tmo <= tmo + 1'b1;
      end
    end
  end
  assign bus.Cambio    = cambio;
  assign bus.got_data  = got;
  assign bus.extendido = extd;
  assign bus.frame_err = err;
endmodule
